// File: rtl/calc_sequencer_if.sv
// Start/busy handshake, operands and registered result bus of the board calculator.
// The front panel (or bench) uses the master modport and calc_sequencer uses the slave modport.
interface calc_sequencer_if #(
   parameter int N = 4
);
   logic           start;
   logic [1:0]     op_sel;
   logic [N-1:0]   x;
   logic [N-1:0]   y;
   logic           busy;
   logic           done;
   logic [2*N-1:0] result;
   logic           carry_out;
   logic           overflow;
   logic           err;

   modport master (
      output start, op_sel, x, y,
      input  busy, done, result, carry_out, overflow, err
   );

   modport slave (
      input  start, op_sel, x, y,
      output busy, done, result, carry_out, overflow, err
   );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator controller: single-cycle add/sub and an N-step shift-add multiply, with registered results.
// Optional macro CALC_SIGNED_MUL_EN turns op_sel 11 into a signed multiply; without it, op_sel 11 is reserved.
module calc_sequencer #(
   parameter int N = 4
) (
   input logic             clk,
   input logic             reset,
   calc_sequencer_if.slave bus
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [N-1:0]   x_q;
   logic [N-1:0]   y_q;
   logic [1:0]     op_q;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [CW-1:0]  count;
   logic           neg_q;

   logic           mul_req;
   logic [N-1:0]   x_load;
   logic [N-1:0]   y_load;
   logic           neg_load;

   logic           sub;
   logic [N-1:0]   y_eff;
   logic [N:0]     sum;
   logic           add_ovf;

   logic [2*N-1:0] acc_step;
   logic [2*N-1:0] mul_final;
   logic           last_step;

   // Decode which requests take the multiply loop and what the loop is seeded with.
   always_comb begin
      mul_req  = (bus.op_sel == 2'b10);
      x_load   = bus.x;
      y_load   = bus.y;
      neg_load = 1'b0;
`ifdef CALC_SIGNED_MUL_EN
      if (bus.op_sel == 2'b11) begin
         mul_req  = 1'b1;
         x_load   = bus.x[N-1] ? -bus.x : bus.x;
         y_load   = bus.y[N-1] ? -bus.y : bus.y;
         neg_load = bus.x[N-1] ^ bus.y[N-1];
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = mul_req ? MUL : EXEC;
            end
         end
         EXEC:    state_next = DONE;
         MUL: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Subtract reuses the adder as x + ~y + 1, so carry_out=1 means no borrow.
   always_comb begin
      sub     = (op_q == 2'b01);
      y_eff   = sub ? ~y_q : y_q;
      sum     = {1'b0, x_q} + {1'b0, y_eff} + {{N{1'b0}}, sub};
      add_ovf = (x_q[N-1] == y_eff[N-1]) && (sum[N-1] != x_q[N-1]);
   end

   always_comb begin
      acc_step  = mplier[0] ? (acc + mcand) : acc;
      mul_final = neg_q ? -acc_step : acc_step;
      last_step = (count == CW'(N - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         op_q   <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         neg_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  x_q    <= bus.x;
                  y_q    <= bus.y;
                  op_q   <= bus.op_sel;
                  acc    <= '0;
                  mcand  <= {{N{1'b0}}, x_load};
                  mplier <= y_load;
                  count  <= '0;
                  neg_q  <= neg_load;
               end
            end
            MUL: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs only move when an operation completes, so the LEDs hold steady during acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.result    <= '0;
         bus.carry_out <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.err       <= 1'b0;
      end else if (state == EXEC) begin
         if (op_q == 2'b11) begin
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.err       <= 1'b1;
         end else begin
            bus.result    <= {{N{1'b0}}, sum[N-1:0]};
            bus.carry_out <= sum[N];
            bus.overflow  <= add_ovf;
            bus.err       <= 1'b0;
         end
      end else if ((state == MUL) && last_step) begin
         bus.result    <= mul_final;
         bus.carry_out <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.err       <= 1'b0;
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: an arithmetic model fills a scoreboard queue at issue time,
// and each test pops that queue and compares when done pulses.
module tb_calc_sequencer;

   localparam int N    = 4;
   localparam int FULL = 1 << N;
   localparam int HALF = 1 << (N - 1);

   typedef struct packed {
      logic [2*N-1:0] result;
      logic           carry;
      logic           ovf;
      logic           err;
   } exp_t;

   logic clk;
   logic reset;

   int tests_run;
   int tests_failed;

   exp_t sb[$];

   calc_sequencer_if #(.N(N)) bus ();

   calc_sequencer #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_signed(input int v);
      return (v >= HALF) ? (v - FULL) : v;
   endfunction

   // Reference arithmetic uses plain integers rather than bit-level adder tricks.
   function automatic exp_t model(input logic [1:0] op, input int xa, input int ya);
      exp_t e;
      int   r;
      int   sr;
      e  = '0;
      r  = 0;
      sr = 0;
      case (op)
         2'b00: begin
            r       = xa + ya;
            sr      = to_signed(xa) + to_signed(ya);
            e.result = (2*N)'(r % FULL);
            e.carry  = (r >= FULL);
            e.ovf    = (sr > HALF - 1) || (sr < -HALF);
         end
         2'b01: begin
            r       = xa - ya;
            sr      = to_signed(xa) - to_signed(ya);
            e.result = (2*N)'((r + FULL) % FULL);
            e.carry  = (xa >= ya);
            e.ovf    = (sr > HALF - 1) || (sr < -HALF);
         end
         2'b10: begin
            e.result = (2*N)'(xa * ya);
         end
         default: begin
`ifdef CALC_SIGNED_MUL_EN
            sr       = to_signed(xa) * to_signed(ya);
            e.result = (2*N)'(sr);
`else
            e.err    = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("result=%h carry=%b ovf=%b err=%b", e.result, e.carry, e.ovf, e.err);
   endfunction

   function automatic exp_t observed();
      return {bus.result, bus.carry_out, bus.overflow, bus.err};
   endfunction

   task automatic issue_op(input logic [1:0] op, input int xa, input int ya, input bit push);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_sel = op;
      bus.x      = N'(xa);
      bus.y      = N'(ya);
      if (push) sb.push_back(model(op, xa, ya));
      @(posedge clk);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.op_sel = 2'($urandom);
      bus.x      = N'($urandom);
      bus.y      = N'($urandom);
   endtask

   // Called at the falling edge right after acceptance; lat counts rising edges until done is seen.
   task automatic wait_done(output int lat, output int busy_cycles, output bit seen);
      lat         = 0;
      busy_cycles = bus.busy ? 1 : 0;
      seen        = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         if (bus.done) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      int act;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if ({bus.busy, bus.done, observed()} !== {2'b00, exp_t'(0)}) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b %s, want busy=0 done=0 %s",
                  bus.busy, bus.done, fmt(observed()), fmt(exp_t'(0)));
      end
      act = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.busy || bus.done) act++;
      end
      tests_run++;
      if (act !== 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_idle: got %0d active cycles, want 0", act);
      end
   endtask

   task automatic test_add();
      int   lat, bc;
      bit   seen;
      exp_t e;
      issue_op(2'b00, 7, 5, 1'b1);
      wait_done(lat, bc, seen);
      tests_run++;
      if (!seen || lat !== 1 || bc !== 2) begin
         tests_failed++;
         $display("[TB] FAIL add_latency: got seen=%b lat=%0d busy=%0d, want seen=1 lat=1 busy=2",
                  seen, lat, bc);
      end
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (observed() !== e) begin
            tests_failed++;
            $display("[TB] FAIL add_7_5: got %s, want %s", fmt(observed()), fmt(e));
         end
      end else sb.delete();
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL add_done_pulse: got done=%b busy=%b, want done=0 busy=0", bus.done, bus.busy);
      end
   endtask

   task automatic test_subtract();
      int   lat, bc;
      bit   seen;
      exp_t e;
      exp_t prev;
      int   xs[2] = '{3, 5};
      int   ys[2] = '{5, 3};
      for (int i = 0; i < 2; i++) begin
         prev = observed();
         issue_op(2'b01, xs[i], ys[i], 1'b1);
         tests_run++;
         if (observed() !== prev) begin
            tests_failed++;
            $display("[TB] FAIL sub_hold_%0d: got %s, want %s", i, fmt(observed()), fmt(prev));
         end
         wait_done(lat, bc, seen);
         if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            tests_run++;
            if (observed() !== e || lat !== 1) begin
               tests_failed++;
               $display("[TB] FAIL sub_%0d_%0d: got %s lat=%0d, want %s lat=1",
                        xs[i], ys[i], fmt(observed()), lat, fmt(e));
            end
         end else begin
            tests_run++;
            tests_failed++;
            sb.delete();
            $display("[TB] FAIL sub_timeout: got no done in %0d cycles, want done", lat);
         end
      end
   endtask

   task automatic test_multiply();
      int   lat, bc;
      bit   seen;
      exp_t e;
      issue_op(2'b10, 15, 15, 1'b1);
      wait_done(lat, bc, seen);
      tests_run++;
      if (!seen || lat !== N || bc !== N + 1) begin
         tests_failed++;
         $display("[TB] FAIL mul_latency: got seen=%b lat=%0d busy=%0d, want seen=1 lat=%0d busy=%0d",
                  seen, lat, bc, N, N + 1);
      end
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (observed() !== e) begin
            tests_failed++;
            $display("[TB] FAIL mul_15_15: got %s, want %s", fmt(observed()), fmt(e));
         end
      end else sb.delete();
   endtask

   task automatic test_busy_ignore();
      int   lat, bc, extra;
      bit   seen;
      exp_t e;
      issue_op(2'b10, 3, 4, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_sel = 2'b00;
      bus.x      = N'(1);
      bus.y      = N'(1);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, bc, seen);
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (observed() !== e) begin
            tests_failed++;
            $display("[TB] FAIL busy_ignore_result: got %s, want %s", fmt(observed()), fmt(e));
         end
      end else begin
         tests_run++;
         tests_failed++;
         sb.delete();
         $display("[TB] FAIL busy_ignore_timeout: got no done in %0d cycles, want done", lat);
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.busy) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("[TB] FAIL busy_ignore_queued: got %0d active cycles, want 0", extra);
      end
   endtask

   task automatic test_reset_abort();
      int   lat, bc, act;
      bit   seen;
      exp_t e;
      issue_op(2'b10, 9, 9, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if ({bus.busy, bus.done, observed()} !== {2'b00, exp_t'(0)}) begin
         tests_failed++;
         $display("[TB] FAIL abort_clear: got busy=%b done=%b %s, want busy=0 done=0 %s",
                  bus.busy, bus.done, fmt(observed()), fmt(exp_t'(0)));
      end
      @(negedge clk);
      reset = 1'b0;
      act = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.busy) act++;
      end
      tests_run++;
      if (act !== 0) begin
         tests_failed++;
         $display("[TB] FAIL abort_no_done: got %0d active cycles, want 0", act);
      end
      issue_op(2'b00, 2, 2, 1'b1);
      wait_done(lat, bc, seen);
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (observed() !== e) begin
            tests_failed++;
            $display("[TB] FAIL abort_then_add: got %s, want %s", fmt(observed()), fmt(e));
         end
      end else begin
         tests_run++;
         tests_failed++;
         sb.delete();
         $display("[TB] FAIL abort_then_add_timeout: got no done in %0d cycles, want done", lat);
      end
   endtask

   task automatic test_reserved();
      int   lat, bc;
      bit   seen;
      exp_t e;
      int   want_lat;
`ifdef CALC_SIGNED_MUL_EN
      want_lat = N;
`else
      want_lat = 1;
`endif
      issue_op(2'b11, 13, 5, 1'b1);
      wait_done(lat, bc, seen);
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (observed() !== e || lat !== want_lat) begin
            tests_failed++;
            $display("[TB] FAIL op11_d_5: got %s lat=%0d, want %s lat=%0d",
                     fmt(observed()), lat, fmt(e), want_lat);
         end
      end else begin
         tests_run++;
         tests_failed++;
         sb.delete();
         $display("[TB] FAIL op11_timeout: got no done in %0d cycles, want done", lat);
      end
   endtask

   task automatic test_back_to_back();
      int         lat, bc;
      bit         seen;
      exp_t       e;
      logic [1:0] op;
      int         xa, ya;
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         xa = $urandom_range(0, FULL - 1);
         ya = $urandom_range(0, FULL - 1);
         if (i == 0) begin
            op = 2'b10;
            xa = FULL - 1;
            ya = 0;
         end
         issue_op(op, xa, ya, 1'b1);
         wait_done(lat, bc, seen);
         if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            tests_run++;
            if (observed() !== e) begin
               tests_failed++;
               $display("[TB] FAIL b2b_%0d op=%0d x=%0d y=%0d: got %s, want %s",
                        i, op, xa, ya, fmt(observed()), fmt(e));
            end
         end else begin
            tests_run++;
            tests_failed++;
            sb.delete();
            $display("[TB] FAIL b2b_%0d_timeout: got no done in %0d cycles, want done", i, lat);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.op_sel   = 2'b00;
      bus.x        = '0;
      bus.y        = '0;
      test_reset();
      test_add();
      test_subtract();
      test_multiply();
      test_busy_ignore();
      test_reset_abort();
      test_reserved();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running at %0t, want finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
